// File: rtl/fft_pkg.sv
// Shared definitions for the FFT address sequencer: FSM encoding and width helpers
// derived from the transform size.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int addr_w(input int log2n);
        return log2n;
    endfunction

    function automatic int k_w(input int log2n);
        return log2n - 1;
    endfunction

    function automatic int stage_w(input int log2n);
        return (log2n > 1) ? $clog2(log2n) : 1;
    endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register carrying {valid, data}; valid and data clear on reset so a
// reset mid-transform leaves nothing in flight.
module fft_delay_line #(
    parameter int DEPTH = 6,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/fft_addr_gen.sv
// In-place radix-2 DIF address/twiddle sequencer: issues butterfly read addresses and k,
// then replays the addresses as write-backs after the datapath latency.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int  N        = 8192,
    parameter int  LOG2N    = $clog2(N),
    parameter int  PIPE_LAT = 6,
    localparam int ADDR_W   = addr_w(LOG2N),
    localparam int K_W      = k_w(LOG2N),
    localparam int STAGE_W  = stage_w(LOG2N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               ready,
    output logic               rd_valid,
    output logic [ADDR_W-1:0]  rd_addr_a,
    output logic [ADDR_W-1:0]  rd_addr_b,
    output logic [K_W-1:0]     k,
    output logic [STAGE_W-1:0] stage,
    output logic               wr_valid,
    output logic [ADDR_W-1:0]  wr_addr_a,
    output logic [ADDR_W-1:0]  wr_addr_b,
    output logic               busy,
    output logic               done,
    output state_t             dbg_state
);

    localparam int DRAIN_W = $clog2(PIPE_LAT + 1);
    localparam logic [K_W-1:0]     B_LAST = K_W'(N / 2 - 1);
    localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(LOG2N - 1);
    localparam logic [DRAIN_W-1:0] D_LAST = DRAIN_W'(PIPE_LAT - 1);

    state_t             r_state;
    logic [STAGE_W-1:0] r_s;
    logic [K_W-1:0]     r_b;
    logic [DRAIN_W-1:0] r_drain;

    logic [STAGE_W-1:0] w_p;
    logic [ADDR_W-1:0]  w_half;
    logic [ADDR_W-1:0]  w_mask;
    logic [ADDR_W-1:0]  w_b_ext;
    logic [ADDR_W-1:0]  w_addr_a;
    logic [ADDR_W-1:0]  w_addr_b;
    logic [K_W-1:0]     w_k;
    logic [2*ADDR_W-1:0] w_wr_data;

    // Bits of b at or above p move up by one, leaving a 0 at p for the upper leg.
    always_comb begin
        w_p      = S_LAST - r_s;
        w_half   = ADDR_W'(1) << w_p;
        w_mask   = w_half - ADDR_W'(1);
        w_b_ext  = {1'b0, r_b};
        w_addr_a = ((w_b_ext & ~w_mask) << 1) | (w_b_ext & w_mask);
        w_addr_b = w_addr_a | w_half;
        w_k      = K_W'(w_b_ext & w_mask) << r_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_s       <= '0;
            r_b       <= '0;
            r_drain   <= '0;
            rd_valid  <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            k         <= '0;
            stage     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_s <= '0;
                    r_b <= '0;
                    if (start) begin
                        r_state <= ST_RUN;
                        busy    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ready) begin
                        rd_valid  <= 1'b1;
                        rd_addr_a <= w_addr_a;
                        rd_addr_b <= w_addr_b;
                        k         <= w_k;
                        stage     <= r_s;
                        if (r_b == B_LAST) begin
                            r_b     <= '0;
                            r_drain <= '0;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_b <= r_b + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Hold off the next stage until every write of this stage has left.
                    if (r_drain == D_LAST) begin
                        if (r_s == S_LAST) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_s     <= r_s + 1'b1;
                            r_state <= ST_RUN;
                        end
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dbg_state = r_state;

    fft_delay_line #(
        .DEPTH (PIPE_LAT),
        .WIDTH (2 * ADDR_W)
    ) u_wb_delay (
        .clk     (clk),
        .rst     (rst),
        .i_valid (rd_valid),
        .i_data  ({rd_addr_a, rd_addr_b}),
        .o_valid (wr_valid),
        .o_data  (w_wr_data)
    );

    assign wr_addr_a = w_wr_data[2*ADDR_W-1:ADDR_W];
    assign wr_addr_b = w_wr_data[ADDR_W-1:0];

endmodule

// File: tb/tb_fft_addr_gen.sv
// Scoreboard bench for fft_addr_gen: an N=8 and an N=8192 instance checked against an
// arithmetic model of the DIF butterfly ordering and the documented cycle timing.
module tb_fft_addr_gen;

    localparam int PL = 6;

    typedef struct packed {
        logic [3:0]  st;
        logic [12:0] a;
        logic [12:0] b;
        logic [11:0] k;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_drv = 1'b0;
    logic ready_drv = 1'b0;
    bit   use_big = 1'b0;
    int   cyc = 0;

    // small instance (N=8)
    logic s_start, s_ready, s_rd_valid, s_wr_valid, s_busy, s_done;
    logic [2:0] s_rd_a, s_rd_b, s_wr_a, s_wr_b;
    logic [1:0] s_k, s_stage, s_state;
    // large instance (N=8192)
    logic l_start, l_ready, l_rd_valid, l_wr_valid, l_busy, l_done;
    logic [12:0] l_rd_a, l_rd_b, l_wr_a, l_wr_b;
    logic [11:0] l_k;
    logic [3:0]  l_stage;
    logic [1:0]  l_state;

    logic m_rd_valid, m_wr_valid, m_busy, m_done;
    logic [12:0] m_rd_a, m_rd_b, m_wr_a, m_wr_b;
    logic [11:0] m_k;
    logic [3:0]  m_stage;
    logic [1:0]  m_state;

    rd_exp_t     exp_rd_q[$];
    logic [25:0] exp_wr_q[$];
    int          rd_time_q[$];
    int          rd_log[$];

    int  checks = 0;
    int  errors = 0;
    bit  run_active = 1'b0;
    bit  done_seen = 1'b0;
    int  done_cyc = 0;
    int  last_wr_cyc = 0;
    int  last_rd_cyc = 0;
    int  prev_stage = -1;
    int  wr_since_stage = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign s_start = use_big ? 1'b0 : start_drv;
    assign s_ready = use_big ? 1'b0 : ready_drv;
    assign l_start = use_big ? start_drv : 1'b0;
    assign l_ready = use_big ? ready_drv : 1'b0;

    fft_addr_gen #(.N(8), .PIPE_LAT(PL)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .ready(s_ready),
        .rd_valid(s_rd_valid), .rd_addr_a(s_rd_a), .rd_addr_b(s_rd_b), .k(s_k),
        .stage(s_stage), .wr_valid(s_wr_valid), .wr_addr_a(s_wr_a), .wr_addr_b(s_wr_b),
        .busy(s_busy), .done(s_done), .dbg_state(s_state)
    );

    fft_addr_gen #(.N(8192), .PIPE_LAT(PL)) u_big (
        .clk(clk), .rst(rst), .start(l_start), .ready(l_ready),
        .rd_valid(l_rd_valid), .rd_addr_a(l_rd_a), .rd_addr_b(l_rd_b), .k(l_k),
        .stage(l_stage), .wr_valid(l_wr_valid), .wr_addr_a(l_wr_a), .wr_addr_b(l_wr_b),
        .busy(l_busy), .done(l_done), .dbg_state(l_state)
    );

    always_comb begin
        if (use_big) begin
            m_rd_valid = l_rd_valid; m_wr_valid = l_wr_valid;
            m_busy = l_busy; m_done = l_done; m_state = l_state;
            m_rd_a = l_rd_a; m_rd_b = l_rd_b; m_wr_a = l_wr_a; m_wr_b = l_wr_b;
            m_k = l_k; m_stage = l_stage;
        end else begin
            m_rd_valid = s_rd_valid; m_wr_valid = s_wr_valid;
            m_busy = s_busy; m_done = s_done; m_state = s_state;
            m_rd_a = {10'd0, s_rd_a}; m_rd_b = {10'd0, s_rd_b};
            m_wr_a = {10'd0, s_wr_a}; m_wr_b = {10'd0, s_wr_b};
            m_k = {10'd0, s_k}; m_stage = {2'd0, s_stage};
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected butterfly order: within stage s, group size 2*half, legs half apart.
    task automatic push_model(input int lg);
        int n, half, lo, a, bb, kk;
        rd_exp_t e;
        n = 1 << lg;
        for (int s = 0; s < lg; s++) begin
            half = n >> (s + 1);
            for (int b = 0; b < n / 2; b++) begin
                lo = b % half;
                a  = (b / half) * 2 * half + lo;
                bb = a + half;
                kk = lo * (1 << s);
                e.st = 4'(s); e.a = 13'(a); e.b = 13'(bb); e.k = 12'(kk);
                exp_rd_q.push_back(e);
                exp_wr_q.push_back({13'(a), 13'(bb)});
            end
        end
    endtask

    task automatic flush_sb();
        exp_rd_q.delete();
        exp_wr_q.delete();
        rd_time_q.delete();
        run_active = 1'b0;
        prev_stage = -1;
        wr_since_stage = 0;
    endtask

    // Monitor: reads first, then writes, then done, all sampled on the falling edge.
    always @(negedge clk) begin
        int n_half;
        rd_exp_t e;
        logic [25:0] w;
        int t0;
        n_half = use_big ? 4096 : 4;
        if (m_rd_valid === 1'b1) begin
            if (prev_stage >= 0 && int'(m_stage) != prev_stage) begin
                chk("wr_count", wr_since_stage, n_half);
                chk("drain_gap", (cyc - last_rd_cyc) >= PL + 1, 1);
                wr_since_stage = 0;
            end
            prev_stage = int'(m_stage);
            last_rd_cyc = cyc;
            rd_time_q.push_back(cyc);
            rd_log.push_back(cyc);
            if (exp_rd_q.size() == 0) begin
                chk("rd_extra", 1, 0);
            end else begin
                e = exp_rd_q.pop_front();
                chk("rd_addr_a", m_rd_a, e.a);
                chk("rd_addr_b", m_rd_b, e.b);
                chk("rd_k", m_k, e.k);
                chk("rd_stage", m_stage, e.st);
            end
            if (use_big) chk("k_range", m_k <= 12'd4095, 1);
        end
        if (m_wr_valid === 1'b1) begin
            wr_since_stage++;
            last_wr_cyc = cyc;
            if (exp_wr_q.size() == 0) begin
                chk("wr_extra", 1, 0);
            end else begin
                w = exp_wr_q.pop_front();
                chk("wr_addr_a", m_wr_a, w[25:13]);
                chk("wr_addr_b", m_wr_b, w[12:0]);
                if (rd_time_q.size() != 0) begin
                    t0 = rd_time_q.pop_front();
                    chk("wr_lat", cyc - t0, PL);
                end
            end
        end
        if (m_done === 1'b1) begin
            if (!run_active) begin
                chk("done_unexp", 1, 0);
            end else begin
                chk("done_lat", cyc, last_wr_cyc + 1);
                chk("done_busy", m_busy, 0);
                chk("wr_count_last", wr_since_stage, n_half);
                chk("done_rd_left", exp_rd_q.size(), 0);
                chk("done_wr_left", exp_wr_q.size(), 0);
                done_seen = 1'b1;
                done_cyc = cyc;
                run_active = 1'b0;
            end
        end
    end

    // mode: 0 ready high, 1 ready 1,0,1,0,1,0,1 then high, 2 random
    task automatic run_xform(input bit big, input int mode, input int mid_start,
                             input int rst_at, input bit chk_total);
        int t0, i, n_cyc, lg;
        lg = big ? 13 : 3;
        use_big = big;
        push_model(lg);
        rd_log.delete();
        rd_time_q.delete();
        prev_stage = -1;
        wr_since_stage = 0;
        done_seen = 1'b0;
        run_active = 1'b1;
        @(posedge clk); #1;
        start_drv = 1'b1;
        ready_drv = 1'b0;
        t0 = cyc;
        @(posedge clk); #1;
        start_drv = 1'b0;
        chk("busy_rise", m_busy, 1);
        n_cyc = 0;
        while (!done_seen && n_cyc < 60000) begin
            i = cyc - t0 - 1;
            case (mode)
                1:       ready_drv = (i < 7) ? (i % 2 == 0) : 1'b1;
                2:       ready_drv = ($urandom_range(0, 3) != 0);
                default: ready_drv = 1'b1;
            endcase
            start_drv = (mid_start != 0 && cyc == t0 + mid_start);
            if (rst_at != 0 && cyc == t0 + rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                start_drv = 1'b0;
                ready_drv = 1'b0;
                flush_sb();
                chk("rst_outs", {m_rd_valid, m_rd_a, m_rd_b, m_k, m_stage,
                                 m_wr_valid, m_wr_a, m_wr_b, m_busy, m_done}, 0);
                chk("rst_state", m_state, 0);
                return;
            end
            @(posedge clk); #1;
            n_cyc++;
        end
        start_drv = 1'b0;
        ready_drv = 1'b0;
        if (!done_seen) begin
            chk("timeout", 0, 1);
            flush_sb();
        end else begin
            if (chk_total) chk("total_cycles", done_cyc - t0, 1 + lg * ((1 << lg) / 2 + PL) + 1);
            if (mode == 1) begin
                chk("bubble_cnt", rd_log.size() >= 5, 1);
                if (rd_log.size() >= 5) begin
                    chk("bubble_rd0", rd_log[0] - t0, 2);
                    chk("bubble_rd1", rd_log[1] - t0, 4);
                    chk("bubble_rd2", rd_log[2] - t0, 6);
                    chk("bubble_rd3", rd_log[3] - t0, 8);
                    chk("stage1_first", rd_log[4] - t0, 8 + PL + 1);
                end
            end
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        use_big = 1'b0;
        #1;
        chk("reset_small", {s_rd_valid, s_rd_a, s_rd_b, s_k, s_stage, s_wr_valid,
                            s_wr_a, s_wr_b, s_busy, s_done}, 0);
        chk("reset_big", {l_rd_valid, l_rd_a, l_rd_b, l_k, l_stage, l_wr_valid,
                          l_wr_a, l_wr_b, l_busy, l_done}, 0);
        chk("reset_state", s_state, 0);

        run_xform(1'b0, 0, 0, 0, 1'b1);
        run_xform(1'b0, 1, 0, 0, 1'b0);
        run_xform(1'b0, 0, 3, 13, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_idle", {m_busy, m_rd_valid, m_wr_valid}, 0);
        run_xform(1'b0, 0, 0, 0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            run_xform(1'b0, 2, 0, 0, 1'b0);
        end
        run_xform(1'b1, 0, 0, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_addr_gen.md
# fft_addr_gen

In-place radix-2 DIF address and twiddle sequencer for the shared-butterfly FFT. It walks all log2(N) stages and issues per butterfly the two data-memory read addresses and the twiddle exponent `k` that drives `w_gen`. It also issues the matching write-back addresses, delayed by the fixed datapath latency. Between stages it drains the pipeline so that in-place reads never overtake pending writes.

## Interface
- `N`, 8192: FFT size, power of two, ≥ 8.
- `LOG2N`, $clog2(N): stage count and address width.
- `PIPE_LAT`, 6: cycles from `rd_valid` to the matching `wr_valid` (twiddle latency 2 plus butterfly latency). Must be ≥ 1.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a transform. Sampled only in IDLE.
- `ready`  in  1  datapath accepts an issue this cycle. When low, a bubble is inserted.
- `rd_valid`  out  1  read addresses and `k` are valid.
- `rd_addr_a`  out  LOG2N  upper-leg read address.
- `rd_addr_b`  out  LOG2N  lower-leg read address.
- `k`  out  LOG2N-1  twiddle exponent for `w_gen`. W = exp(-j2πk/N).
- `stage`  out  $clog2(LOG2N)  stage of the current read issue.
- `wr_valid`  out  1  write-back addresses are valid.
- `wr_addr_a`  out  LOG2N  upper-leg write address.
- `wr_addr_b`  out  LOG2N  lower-leg write address.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse when the transform has finished.

## Operation
- FSM states:
  - IDLE: `start` moves to RUN. Stage counter `s` = 0 and butterfly counter `b` = 0.
  - RUN: when `ready` = 1, issue butterfly `b` and increment `b`. If `b` = N/2-1, clear `b` and go to DRAIN.
  - DRAIN: count PIPE_LAT cycles, then branch:
    - `s` = LOG2N-1: go to DONE.
    - otherwise: increment `s` and return to RUN.
  - DONE: pulse `done`, go to IDLE.
- Address rules, with half = N >> (s+1) and bit position p = LOG2N-1-s:
  - `rd_addr_a` = `b` with a 0 inserted at bit p.
  - `rd_addr_b` = `rd_addr_a` | half.
  - `k` = (`b` & (half-1)) << s, truncated to LOG2N-1 bits, so 0 ≤ `k` < N/2.
- Write-back delay line:
  - Depth PIPE_LAT. Each entry is {valid, addr_a, addr_b}.
  - Shifts every cycle, independent of `ready`.
  - `wr_*` are the delay-line output.
- `ready` low in RUN: counters hold and `rd_valid` = 0 next cycle. `ready` is ignored outside RUN.
- `start` while busy: ignored.
- `rst` mid-transform:
  - FSM returns to IDLE and the counters clear.
  - All delay-line valid bits clear.
  - No `wr_valid` or `done` follows.
- Reset values: all outputs 0.

## Timing
- All outputs are registered.
- `start` high in cycle t (IDLE): `busy` = 1 and state RUN in cycle t+1.
- RUN with `ready` = 1 in cycle c: `rd_valid` and its addresses appear in cycle c+1.
- `wr_valid` for that butterfly appears in cycle c+1+PIPE_LAT.
- With `ready` held high, a stage issues N/2 consecutive `rd_valid` cycles.
- The last read of a stage (issue cycle c) is followed by DRAIN in cycles c+1 … c+PIPE_LAT. The next stage's first issue cycle is c+PIPE_LAT+1.
  - Therefore the last write of stage s precedes the first read of stage s+1 by at least one cycle.
- `done` is high in the cycle immediately after the final `wr_valid`. `busy` falls in that same cycle.
- Total with `ready` always high: 1 + LOG2N·(N/2 + PIPE_LAT) + 1 cycles from `start` to `done`.

## Structure
- Shared `fft_pkg` holds:
  - FSM state encoding (IDLE, RUN, DRAIN, DONE).
  - Width helpers: `ADDR_W` = LOG2N, `K_W` = LOG2N-1, `STAGE_W`.
- Sub-module `fft_delay_line`: parameterized depth/width shift register with a resettable valid bit. It implements the write-back path.

## Test plan
- N=8, PIPE_LAT=6, `ready` high. Stage 0 must read (a,b,k) = (0,4,0), (1,5,1), (2,6,2), (3,7,3).
- Same run, stage 1 must read (0,2,0), (1,3,2), (4,6,0), (5,7,2). Stage 2 must read (0,1,0), (2,3,0), (4,5,0), (6,7,0).
- Each `wr_valid` must appear exactly 6 cycles after its `rd_valid` with identical addresses. `done` must occur 1 cycle after the 12th write. Total cycles from `start` to `done` = 32.
- `ready` toggled 1,0,1,0 during stage 0:
  - `rd_valid` shows bubbles and no butterfly is skipped or repeated.
  - DRAIN still begins only after the 4th issue.
- `start` pulsed mid-run has no effect. `rst` asserted during stage 1:
  - All outputs are 0 next cycle and no further `wr_valid` or `done` appears.
  - A fresh `start` then reproduces the first stage-0 sequence exactly.
- N=8192: `k` must never exceed 4095. At the start of each stage, the number of `wr_valid` cycles of the previous stage must equal 4096 (scoreboard check).
